// File: rtl/alu_exec_unit.sv
// Integer execute unit: single-cycle ALU ops plus iterative shift-add multiply and restoring divide.
// Valid/ready handshakes on both sides; one operation in flight at a time.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ALUOp,
    input  logic [6:0]       func7,
    input  logic [2:0]       func3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
    } op_t;

    state_t           r_state, w_nextState;
    op_t              w_op;
    logic [CW-1:0]    r_count;
    logic             r_isMul, r_wantRem, r_negQ, r_negR, r_illegal;
    logic [WIDTH-1:0] r_opA, r_opB, r_acc, r_result;

    logic [SHW-1:0]   w_shamt;
    logic             w_isDiv, w_signedDiv, w_remOp, w_bZero, w_overflow, w_bypass, w_iterative;
    logic [WIDTH-1:0] w_magA, w_magB, w_quick, w_accMul, w_remNext, w_quoNext, w_quoFinal, w_remFinal;
    logic [WIDTH:0]   w_remShift, w_diff;

    always_comb begin
        w_op = OP_ILL;
        case (ALUOp)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: begin
                if (func7 == 7'b0000000) begin
                    case (func3)
                        3'b000:  w_op = OP_ADD;
                        3'b001:  w_op = OP_SLL;
                        3'b010:  w_op = OP_SLT;
                        3'b011:  w_op = OP_SLTU;
                        3'b100:  w_op = OP_XOR;
                        3'b101:  w_op = OP_SRL;
                        3'b110:  w_op = OP_OR;
                        default: w_op = OP_AND;
                    endcase
                end else if (func7 == 7'b0100000) begin
                    if (func3 == 3'b000)      w_op = OP_SUB;
                    else if (func3 == 3'b101) w_op = OP_SRA;
                end else if (func7 == 7'b0000001) begin
                    case (func3)
                        3'b000:  w_op = OP_MUL;
                        3'b100:  w_op = OP_DIV;
                        3'b101:  w_op = OP_DIVU;
                        3'b110:  w_op = OP_REM;
                        3'b111:  w_op = OP_REMU;
                        default: w_op = OP_ILL;
                    endcase
                end
            end
            default: w_op = OP_ILL;
        endcase
    end

    assign w_shamt     = op_b[SHW-1:0];
    assign w_isDiv     = (w_op == OP_DIV) || (w_op == OP_DIVU) || (w_op == OP_REM) || (w_op == OP_REMU);
    assign w_signedDiv = (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_remOp     = (w_op == OP_REM) || (w_op == OP_REMU);
    assign w_bZero     = (op_b == '0);
    assign w_overflow  = w_signedDiv && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&op_b);
    assign w_bypass    = w_isDiv && (w_bZero || w_overflow);
    assign w_iterative = (w_op == OP_MUL) || (w_isDiv && !w_bypass);
    assign w_magA      = (w_signedDiv && op_a[WIDTH-1]) ? -op_a : op_a;
    assign w_magB      = (w_signedDiv && op_b[WIDTH-1]) ? -op_b : op_b;

    // Results that are known at accept time, including the divide corner cases that skip iteration.
    always_comb begin
        w_quick = '0;
        case (w_op)
            OP_ADD:  w_quick = op_a + op_b;
            OP_SUB:  w_quick = op_a - op_b;
            OP_SLL:  w_quick = op_a << w_shamt;
            OP_SLT:  w_quick = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: w_quick = {{(WIDTH-1){1'b0}}, op_a < op_b};
            OP_XOR:  w_quick = op_a ^ op_b;
            OP_SRL:  w_quick = op_a >> w_shamt;
            OP_SRA:  w_quick = WIDTH'($signed(op_a) >>> w_shamt);
            OP_OR:   w_quick = op_a | op_b;
            OP_AND:  w_quick = op_a & op_b;
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (w_bZero)      w_quick = w_remOp ? op_a : '1;
                else if (w_remOp) w_quick = '0;
                else              w_quick = op_a;
            end
            default: w_quick = '0;
        endcase
    end

    assign w_accMul   = r_opB[0] ? (r_acc + r_opA) : r_acc;
    assign w_remShift = {r_acc, r_opA[WIDTH-1]};
    assign w_diff     = w_remShift - {1'b0, r_opB};
    assign w_remNext  = w_diff[WIDTH] ? w_remShift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quoNext  = {r_opA[WIDTH-2:0], ~w_diff[WIDTH]};
    assign w_quoFinal = r_negQ ? -w_quoNext : w_quoNext;
    assign w_remFinal = r_negR ? -w_remNext : w_remNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_nextState = w_iterative ? ITER : DONE;
            end
            ITER: if (r_count == '0) w_nextState = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // For divides r_opA doubles as the quotient shift register and r_acc as the partial remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_isMul   <= 1'b0;
            r_wantRem <= 1'b0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_illegal <= 1'b0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_acc     <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_count   <= CW'(WIDTH-1);
                    r_isMul   <= (w_op == OP_MUL);
                    r_wantRem <= w_remOp;
                    r_negQ    <= w_signedDiv && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    r_negR    <= w_signedDiv && op_a[WIDTH-1];
                    r_illegal <= (w_op == OP_ILL);
                    r_result  <= w_quick;
                    r_acc     <= '0;
                    r_opA     <= (w_op == OP_MUL) ? op_a : w_magA;
                    r_opB     <= (w_op == OP_MUL) ? op_b : w_magB;
                end
                ITER: begin
                    if (r_count != '0) r_count <= r_count - 1'b1;
                    if (r_isMul) begin
                        r_acc <= w_accMul;
                        r_opA <= r_opA << 1;
                        r_opB <= r_opB >> 1;
                    end else begin
                        r_acc <= w_remNext;
                        r_opA <= w_quoNext;
                    end
                    if (r_count == '0)
                        r_result <= r_isMul ? w_accMul : (r_wantRem ? w_remFinal : w_quoFinal);
                end
                default: ;
            endcase
        end
    end

    assign result  = r_result;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed table-driven bench for alu_exec_unit at WIDTH=32, plus hand sequences for
// result hold under back-pressure and reset during an iterative divide.
module tb_alu_exec_unit;
    logic        clk;
    logic        rst_n;
    logic [1:0]  ALUOp;
    logic [6:0]  func7;
    logic [2:0]  func3;
    logic [31:0] op_a, op_b;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] result;
    logic        illegal, busy;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] F7B = 7'b0000000;
    localparam logic [6:0] F7A = 7'b0100000;
    localparam logic [6:0] F7M = 7'b0000001;

    typedef struct {
        logic [1:0]  aop;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .func7(func7), .func3(func3),
        .op_a(op_a), .op_b(op_b), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .illegal(illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic ill, input int lat);
        vec_t v;
        v.aop = aop; v.f7 = f7; v.f3 = f3; v.a = a; v.b = b;
        v.res = res; v.ill = ill; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Present one request, let it be accepted, then count cycles until out_valid (bounded).
    task automatic applyStimulus(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        ALUOp = aop; func7 = f7; func3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consumeResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; ALUOp = 2'b00; func7 = '0; func3 = '0;
        op_a = '0; op_b = '0; in_valid = 1'b0; out_ready = 1'b0;

        addVec(2'b00, F7B, 3'b000, 32'd5,        32'd7,        32'd12,       1'b0, 1);
        addVec(2'b01, F7B, 3'b000, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1);
        addVec(2'b10, F7B, 3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
        addVec(2'b10, F7B, 3'b001, 32'd1,        32'h00000021, 32'd2,        1'b0, 1);
        addVec(2'b10, F7B, 3'b010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1);
        addVec(2'b10, F7B, 3'b011, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
        addVec(2'b10, F7B, 3'b100, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1);
        addVec(2'b10, F7B, 3'b101, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1);
        addVec(2'b10, F7B, 3'b110, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1);
        addVec(2'b10, F7B, 3'b111, 32'h000000F0, 32'h0000003C, 32'h00000030, 1'b0, 1);
        addVec(2'b10, F7A, 3'b000, 32'd10,       32'd3,        32'd7,        1'b0, 1);
        addVec(2'b10, F7A, 3'b101, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1);
        addVec(2'b10, F7M, 3'b000, 32'd6,        32'd7,        32'd42,       1'b0, 33);
        addVec(2'b10, F7M, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33);
        addVec(2'b10, F7M, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33);
        addVec(2'b10, F7M, 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33);
        addVec(2'b10, F7M, 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 33);
        addVec(2'b10, F7M, 3'b101, 32'd100,      32'd7,        32'd14,       1'b0, 33);
        addVec(2'b10, F7M, 3'b111, 32'd100,      32'd7,        32'd2,        1'b0, 33);
        addVec(2'b10, F7M, 3'b101, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1'b0, 1);
        addVec(2'b10, F7M, 3'b111, 32'h00001234, 32'd0,        32'h00001234, 1'b0, 1);
        addVec(2'b10, F7M, 3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b0, 1);
        addVec(2'b10, F7M, 3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b0, 1);
        addVec(2'b10, F7M, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
        addVec(2'b10, F7M, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1);
        addVec(2'b10, F7M, 3'b010, 32'd9,        32'd9,        32'd0,        1'b1, 1);
        addVec(2'b11, F7B, 3'b000, 32'd9,        32'd9,        32'd0,        1'b1, 1);
        addVec(2'b10, F7A, 3'b001, 32'd9,        32'd9,        32'd0,        1'b1, 1);
        addVec(2'b10, 7'b0000010, 3'b000, 32'd9, 32'd9,        32'd0,        1'b1, 1);

        #3;
        checkOutput("reset in_ready",  in_ready,  1'b1);
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset busy",      busy,      1'b0);
        checkOutput("reset result",    result,    32'd0);
        checkOutput("reset illegal",   illegal,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].aop, vecs[i].f7, vecs[i].f3, vecs[i].a, vecs[i].b, lat);
            checkOutput($sformatf("vec%0d latency", i), lat,     vecs[i].lat);
            checkOutput($sformatf("vec%0d result", i),  result,  vecs[i].res);
            checkOutput($sformatf("vec%0d illegal", i), illegal, vecs[i].ill);
            consumeResult();
        end

        // MUL all-ones held under back-pressure while a new request is offered and must be ignored.
        applyStimulus(2'b10, F7M, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        checkOutput("mulhold latency", lat,    33);
        checkOutput("mulhold result",  result, 32'd1);
        @(negedge clk);
        ALUOp = 2'b00; op_a = 32'd50; op_b = 32'd50; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("mulhold result c%0d", k),   result,    32'd1);
            checkOutput($sformatf("mulhold valid c%0d", k),    out_valid, 1'b1);
            checkOutput($sformatf("mulhold in_ready c%0d", k), in_ready,  1'b0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checkOutput("done+ready in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("after drain out_valid", out_valid, 1'b0);
        checkOutput("after drain in_ready",  in_ready,  1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("no queued request", out_valid, 1'b0);

        // Abort an iterative DIVU with reset, then run a fresh ADD.
        @(negedge clk);
        ALUOp = 2'b10; func7 = F7M; func3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        checkOutput("abort busy before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort out_valid", out_valid, 1'b0);
        checkOutput("abort busy",      busy,      1'b0);
        checkOutput("abort in_ready",  in_ready,  1'b1);
        checkOutput("abort result",    result,    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'b00, F7B, 3'b000, 32'd3, 32'd4, lat);
        checkOutput("post-reset add latency", lat,    1);
        checkOutput("post-reset add result",  result, 32'd7);
        consumeResult();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
